// File: rtl/sc_loader_pkg.sv
// rtl/sc_loader_pkg.sv - shared types and constants for the instruction-memory loader
//
// Purpose: holds the loader state enumeration, the default program length
// limit, the length-field width and the byte-lane geometry of a memory word.
// Ports: none (package).
package sc_loader_pkg;

  // Largest accepted program, in 32-bit words (2**ADDR_W for the default ADDR_W).
  localparam int MAX_WORDS = 256;

  // Width of the little-endian word-count field at the head of the stream.
  localparam int LEN_W = 16;

  // A memory word is LANES bytes of LANE_W bits each.
  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int WORD_W = LANES * LANE_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_e;

endpackage

// File: rtl/loader_word_packer.sv
// rtl/loader_word_packer.sv - little-endian byte-to-word assembler for the loader
//
// Purpose: collects data bytes into 32-bit words, byte k of a word landing in
// bits [8k+7:8k], and flags the byte that completes a word.
// Ports:
//   clk_i         clock
//   clr_i         synchronous active-high reset
//   flush_i       restart lane counting at byte 0 (new load)
//   byte_valid_i  a data byte is transferred this cycle
//   byte_i        the data byte
//   word_o        assembled word, valid while word_done_o is high
//   word_done_o   this cycle's byte is lane 3 and completes word_o
module loader_word_packer
  import sc_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              flush_i,
  input  logic              byte_valid_i,
  input  logic [LANE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_done_o
);

  localparam int LANE_BITS = $clog2(LANES);
  localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(LANES - 1);

  logic [LANE_BITS-1:0]          lane_q, lane_d;
  // Lanes 0..2 are held here; lane 3 is taken straight from byte_i so the
  // full word is ready on the same edge that accepts the last byte.
  logic [WORD_W-LANE_W-1:0]      low_q, low_d;

  always_comb begin
    lane_d = lane_q;
    low_d  = low_q;
    if (flush_i) begin
      lane_d = '0;
      low_d  = '0;
    end else if (byte_valid_i) begin
      case (lane_q)
        2'd0:    low_d[7:0]   = byte_i;
        2'd1:    low_d[15:8]  = byte_i;
        2'd2:    low_d[23:16] = byte_i;
        default: low_d        = low_q;
      endcase
      // Wraps from lane 3 back to lane 0 for the next word.
      lane_d = lane_q + LANE_BITS'(1);
    end
  end

  assign word_o      = {byte_i, low_q};
  assign word_done_o = byte_valid_i && !flush_i && (lane_q == LAST_LANE);

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      lane_q <= '0;
      low_q  <= '0;
    end else begin
      lane_q <= lane_d;
      low_q  <= low_d;
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - streams a length-prefixed, checksummed program into instruction memory
//
// Purpose: parses LEN_LO, LEN_HI, 4*N data bytes and an XOR checksum byte,
// writes each assembled word to the instruction memory and releases the CPU
// from reset only after a load whose length and checksum are both good.
// Ports:
//   clk       clock
//   clr       synchronous active-high reset
//   start     one-cycle pulse that begins a load (from IDLE, DONE or ERROR)
//   in_data   stream byte
//   in_valid  in_data is valid
//   in_ready  loader accepts a byte this cycle
//   mem_we    instruction-memory write strobe (one cycle per word)
//   mem_addr  instruction-memory word address
//   mem_din   instruction-memory write data
//   cpu_clrn  active-low CPU reset, high only after a good load
//   busy      load in progress
//   done      last load completed with a good checksum
//   err       last load failed (bad length or bad checksum)
module inst_mem_loader
  import sc_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = sc_loader_pkg::MAX_WORDS
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              cpu_clrn,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  // Words still to be written; reaching the last one moves the FSM to CHECK.
  logic [LEN_W-1:0]  remain_q, remain_d;
  // Next write address. It wraps to 0 after the final word of a full
  // MAX_WORDS load, but no write follows that wrap.
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [7:0]        cksum_q, cksum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;

  logic              loading;
  logic              xfer;
  logic              data_xfer;
  logic              flush;
  logic [LEN_W-1:0]  len_n;
  logic [31:0]       word;
  logic              word_done;

  assign loading   = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                     (state_q == ST_DATA) || (state_q == ST_CHECK);
  assign in_ready  = loading;
  assign busy      = loading;
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_ERROR);
  assign cpu_clrn  = (state_q == ST_DONE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_din   = din_q;

  assign xfer      = in_valid && in_ready;
  assign data_xfer = xfer && (state_q == ST_DATA);
  assign len_n     = {in_data, len_lo_q};

  loader_word_packer u_packer (
    .clk_i        (clk),
    .clr_i        (clr),
    .flush_i      (flush),
    .byte_valid_i (data_xfer),
    .byte_i       (in_data),
    .word_o       (word),
    .word_done_o  (word_done)
  );

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    remain_d = remain_q;
    widx_d   = widx_q;
    cksum_d  = cksum_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    din_d    = din_q;
    flush    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d  = ST_LEN0;
          len_lo_d = '0;
          remain_d = '0;
          widx_d   = '0;
          cksum_d  = '0;
          flush    = 1'b1;
        end
      end

      ST_LEN0: begin
        if (xfer) begin
          len_lo_d = in_data;
          state_d  = ST_LEN1;
        end
      end

      ST_LEN1: begin
        if (xfer) begin
          if ((len_n != '0) && (len_n <= LEN_W'(MAX_WORDS))) begin
            remain_d = len_n;
            state_d  = ST_DATA;
          end else begin
            state_d  = ST_ERROR;
          end
        end
      end

      ST_DATA: begin
        if (data_xfer) begin
          cksum_d = cksum_q ^ in_data;
          if (word_done) begin
            we_d     = 1'b1;
            addr_d   = widx_q;
            din_d    = word;
            widx_d   = widx_q + ADDR_W'(1);
            remain_d = remain_q - LEN_W'(1);
            if (remain_q == LEN_W'(1)) begin
              state_d = ST_CHECK;
            end
          end
        end
      end

      ST_CHECK: begin
        if (xfer) begin
          state_d = (in_data == cksum_q) ? ST_DONE : ST_ERROR;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= ST_IDLE;
      len_lo_q <= '0;
      remain_q <= '0;
      widx_q   <= '0;
      cksum_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      remain_q <= remain_d;
      widx_q   <= widx_d;
      cksum_q  <= cksum_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb/tb_inst_mem_loader.sv - directed self-checking bench for inst_mem_loader
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_din;
  logic        cpu_clrn;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  inst_mem_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .cpu_clrn (cpu_clrn),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every mem_we cycle is logged and applied to a memory model.
  int          wr_n = 0;
  logic [7:0]  wr_addr [1024];
  logic [31:0] wr_din  [1024];
  int          wr_cyc  [1024];
  logic [31:0] mem_model [256];

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr[wr_n & 1023] = mem_addr;
      wr_din[wr_n & 1023]  = mem_din;
      wr_cyc[wr_n & 1023]  = cyc;
      mem_model[mem_addr]  = mem_din;
      wr_n = wr_n + 1;
    end
  end

  logic [31:0] prog [256];
  int          b3_cyc [256];
  int          stalls;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic st, output int xc);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    start    = st;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", 32'(n < 50), 32'd1);
    xc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    in_valid = 1'b0;
    #1;
  endtask

  task automatic send_prog(input int nw, input logic [7:0] ck, input bit rnd);
    int xc;
    int prev;
    logic [31:0] w;
    stalls = 0;
    send_byte(nw[7:0], 1'b0, xc);
    prev = xc;
    send_byte(nw[15:8], 1'b0, xc);
    if (xc != prev + 1) stalls++;
    prev = xc;
    for (int k = 0; k < nw; k++) begin
      w = prog[k];
      for (int j = 0; j < 4; j++) begin
        if (rnd) gap($urandom_range(0, 2));
        send_byte(w[8*j +: 8], rnd && (j == 2), xc);
        if (xc != prev + 1) stalls++;
        prev = xc;
        if (j == 3) b3_cyc[k] = xc;
      end
    end
    if (rnd) gap($urandom_range(1, 3));
    send_byte(ck, 1'b0, xc);
    if (xc != prev + 1) stalls++;
  endtask

  task automatic load_small4();
    prog[0] = 32'h11223344;
    prog[1] = 32'hCAFEF00D;
    prog[2] = 32'h01234567;
    prog[3] = 32'h89ABCDEF;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int xc;
    logic [7:0] cks;
    logic [7:0] b;

    clr      = 1'b1;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we",   32'(mem_we),   32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_din",  mem_din,       32'd0);
    chk("rst_cpu_clrn", 32'(cpu_clrn), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_err",      32'(err),      32'd0);
    @(negedge clk);
    clr = 1'b0; start = 1'b0; in_valid = 1'b0;

    // Single good word 0xDEADBEEF, checksum EF^BE^AD^DE = 0x22.
    prog[0] = 32'hDEADBEEF;
    base = wr_n;
    pulse_start();
    chk("t1_busy_after_start", 32'(busy), 32'd1);
    chk("t1_ready_after_start", 32'(in_ready), 32'd1);
    send_prog(1, 8'h22, 1'b0);
    settle();
    chk("t1_writes",    32'(wr_n - base), 32'd1);
    chk("t1_addr",      32'(wr_addr[base & 1023]), 32'd0);
    chk("t1_din",       wr_din[base & 1023], 32'hDEADBEEF);
    chk("t1_latency",   32'(wr_cyc[base & 1023]), 32'(b3_cyc[0] + 1));
    chk("t1_done",      32'(done), 32'd1);
    chk("t1_cpu_clrn",  32'(cpu_clrn), 32'd1);
    chk("t1_err",       32'(err), 32'd0);
    chk("t1_busy",      32'(busy), 32'd0);
    chk("t1_mem_we",    32'(mem_we), 32'd0);
    chk("t1_addr_hold", 32'(mem_addr), 32'd0);
    chk("t1_din_hold",  mem_din, 32'hDEADBEEF);

    // Same stream with a wrong checksum.
    base = wr_n;
    pulse_start();
    chk("t2_done_cleared", 32'(done), 32'd0);
    chk("t2_clrn_low",     32'(cpu_clrn), 32'd0);
    send_prog(1, 8'h23, 1'b0);
    settle();
    chk("t2_writes",   32'(wr_n - base), 32'd1);
    chk("t2_din",      wr_din[base & 1023], 32'hDEADBEEF);
    chk("t2_err",      32'(err), 32'd1);
    chk("t2_done",     32'(done), 32'd0);
    chk("t2_cpu_clrn", 32'(cpu_clrn), 32'd0);

    // Zero length.
    base = wr_n;
    pulse_start();
    chk("t3_err_cleared", 32'(err), 32'd0);
    send_byte(8'h00, 1'b0, xc);
    send_byte(8'h00, 1'b0, xc);
    settle();
    chk("t3_len0_err",    32'(err), 32'd1);
    chk("t3_len0_busy",   32'(busy), 32'd0);
    chk("t3_len0_writes", 32'(wr_n - base), 32'd0);

    // Length 257.
    pulse_start();
    send_byte(8'h01, 1'b0, xc);
    send_byte(8'h01, 1'b0, xc);
    settle();
    chk("t3_len257_err",    32'(err), 32'd1);
    chk("t3_len257_ready",  32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("t3_len257_writes", 32'(wr_n - base), 32'd0);

    // Full 256-word program, in_valid held continuously.
    cks = 8'h00;
    for (int k = 0; k < 256; k++) begin
      for (int j = 0; j < 4; j++) begin
        b = 8'((k * 4 + j) * 37 + 11);
        prog[k][8*j +: 8] = b;
        cks = cks ^ b;
      end
    end
    base = wr_n;
    pulse_start();
    send_prog(256, cks, 1'b0);
    settle();
    chk("t4_stalls", 32'(stalls), 32'd0);
    chk("t4_writes", 32'(wr_n - base), 32'd256);
    for (int k = 0; k < 256; k++) begin
      chk($sformatf("t4_addr_%0d", k), 32'(wr_addr[(base + k) & 1023]), 32'(k));
      chk($sformatf("t4_din_%0d", k),  wr_din[(base + k) & 1023], prog[k]);
      chk($sformatf("t4_lat_%0d", k),  32'(wr_cyc[(base + k) & 1023]), 32'(b3_cyc[k] + 1));
    end
    chk("t4_done", 32'(done), 32'd1);
    repeat (4) @(negedge clk);
    #1;
    chk("t4_no_extra_write", 32'(wr_n - base), 32'd256);

    // Abort with clr after two of four words; clr also beats start and a byte.
    load_small4();
    base = wr_n;
    pulse_start();
    send_byte(8'h04, 1'b0, xc);
    send_byte(8'h00, 1'b0, xc);
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) begin
        send_byte(prog[k][8*j +: 8], 1'b0, xc);
      end
    end
    @(negedge clk);
    clr      = 1'b1;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h67;
    @(negedge clk);
    clr      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("t5_busy",     32'(busy), 32'd0);
    chk("t5_ready",    32'(in_ready), 32'd0);
    chk("t5_mem_we",   32'(mem_we), 32'd0);
    chk("t5_mem_addr", 32'(mem_addr), 32'd0);
    chk("t5_mem_din",  mem_din, 32'd0);
    chk("t5_cpu_clrn", 32'(cpu_clrn), 32'd0);
    chk("t5_done",     32'(done), 32'd0);
    chk("t5_err",      32'(err), 32'd0);
    chk("t5_writes",   32'(wr_n - base), 32'd2);
    chk("t5_word1",    wr_din[(base + 1) & 1023], 32'hCAFEF00D);
    base = wr_n;
    pulse_start();
    send_prog(4, 8'h8D, 1'b0);
    settle();
    chk("t5_reload_done",   32'(done), 32'd1);
    chk("t5_reload_writes", 32'(wr_n - base), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t5_mem_%0d", k), mem_model[k], prog[k]);
    end

    // Random in_valid gaps and start pulses during DATA.
    base = wr_n;
    pulse_start();
    send_prog(4, 8'h8D, 1'b1);
    settle();
    chk("t6_done",   32'(done), 32'd1);
    chk("t6_err",    32'(err), 32'd0);
    chk("t6_clrn",   32'(cpu_clrn), 32'd1);
    chk("t6_writes", 32'(wr_n - base), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t6_addr_%0d", k), 32'(wr_addr[(base + k) & 1023]), 32'(k));
      chk($sformatf("t6_mem_%0d", k),  mem_model[k], prog[k]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 Parameter: ADDR_W, 8, instruction-memory word-address width.
REQ-002 Parameter: MAX_WORDS, 256, largest accepted program length in words (= 2**ADDR_W).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 clr  input  1  synchronous active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a program load.
REQ-007 in_data  input  8  byte of the load stream.
REQ-008 in_valid  input  1  in_data is valid.
REQ-009 in_ready  output  1  loader accepts a byte this cycle.
REQ-010 mem_we  output  1  write strobe to the instruction memory port.
REQ-011 mem_addr  output  ADDR_W  instruction-memory word address.
REQ-012 mem_din  output  32  word written to the instruction memory.
REQ-013 cpu_clrn  output  1  active-low reset to the CPU core; high only after a good load.
REQ-014 busy  output  1  load in progress.
REQ-015 done  output  1  last load completed with a good checksum.
REQ-016 err  output  1  last load failed because of a bad length or a bad checksum.

Function
REQ-017 Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes, then one checksum byte.
REQ-018 A byte is transferred on any cycle with in_valid && in_ready; in_data is ignored on all other cycles.
REQ-019 States: IDLE, LEN0, LEN1, DATA, CHECK, DONE, ERROR.
REQ-020 in_ready SHALL be 1 exactly in LEN0, LEN1, DATA and CHECK; busy SHALL be 1 in the same states.
REQ-021 start in IDLE, DONE or ERROR -> LEN0: clears the word counter, byte counter and checksum, drives cpu_clrn=0, and clears done and err; start in any other state is ignored.
REQ-022 LEN0 -> LEN1 on transfer; LEN1 -> DATA on transfer if 1 <= N <= MAX_WORDS, otherwise -> ERROR.
REQ-023 DATA: the k-th byte of a word (k=0..3) lands in bits [8k+7:8k] (little-endian); every data byte is XOR-folded into an 8-bit checksum register.
REQ-024 On the edge that accepts byte 3, mem_din <= assembled word, mem_addr <= word index, and mem_we <= 1 for exactly the following cycle; that is a 1-cycle write latency.
REQ-025 in_ready SHALL stay high during the write cycle, so back-to-back bytes are accepted with no stall.
REQ-026 The word index increments after each write; after word N-1 the state moves to CHECK on that same edge.
REQ-027 CHECK: on transfer, a byte equal to the checksum register -> DONE, otherwise -> ERROR.
REQ-028 DONE: cpu_clrn=1, done=1, held until start or clr.
REQ-029 ERROR: cpu_clrn=0, err=1, held until start or clr.
REQ-030 mem_we SHALL be 0 in every cycle not covered by REQ-024; mem_addr and mem_din hold their last values.
REQ-031 No timeout: an unbounded in_valid gap leaves the state and counters unchanged.
REQ-032 N = MAX_WORDS SHALL write addresses 0..MAX_WORDS-1 with no wrap and no extra write.

Reset
REQ-033 clr=1 at a rising edge forces IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_din=0, cpu_clrn=0, busy=0, done=0, err=0, and zero counters and checksum.
REQ-034 clr SHALL take priority over start and over any transfer in the same cycle.
REQ-035 clr during a load aborts it; memory words already written are not cleared, and the CPU stays in reset.

Structure
REQ-036 A shared package sc_loader_pkg SHALL hold the state enumeration, MAX_WORDS, the 16-bit length width and the byte-lane count (4).
REQ-037 One sub-module, loader_word_packer, SHALL do byte-lane assembly and the 0..3 byte counter and emit a word-complete pulse; the FSM and the counters stay in the top level.

Verification
REQ-038 clr, start, bytes 01 00 EF BE AD DE 22 -> single mem_we with addr 0 and din 0xDEADBEEF, then done=1, cpu_clrn=1, err=0.
REQ-039 Same stream with checksum 0x23 -> one write to addr 0, then err=1, done=0, cpu_clrn=0.
REQ-040 Length 00 00 and length 01 01 (257) -> ERROR right after LEN_HI, no mem_we pulses, err=1.
REQ-041 N=256 with in_valid held continuously -> 256 writes at addresses 0..255 in increasing order, each one cycle after its 4th byte, and no stall cycles.
REQ-042 clr asserted after 2 of 4 words -> next cycle IDLE and all outputs at reset values; start then a full good stream -> done=1.
REQ-043 start pulsed during DATA, in_valid toggled randomly -> start ignored; final memory contents and the done result match the uninterrupted reference stream.
